// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad time-entry front end.
package keypad_pkg;

    localparam int unsigned NUM_KEYS = 10;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } key_state_t;

endpackage

// File: rtl/keypad_onehot_encoder.sv
// Maps the synchronized keypad lines to a digit code; only a single pressed key is valid.
module keypad_onehot_encoder
    import keypad_pkg::*;
(
    input  logic [NUM_KEYS-1:0] keys,
    output logic                valid,
    output bcd_t                code
);

    logic [3:0] ones;

    always_comb begin
        ones = '0;
        code = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                ones = ones + 4'd1;
                code = 4'(i);
            end
        end
        valid = (ones == 4'd1);
    end

endmodule

// File: rtl/keypad_entry.sv
// Synchronizes and debounces the keypad, accepting one digit per press into a 3-digit BCD shift register.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                entry_en,
    input  logic                clear,
    output logic [3:0]          Min,
    output logic [3:0]          TenSec,
    output logic [3:0]          Sec,
    output logic                digit_strobe,
    output logic                time_nonzero
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] s1_q, s2_q;
    key_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    bcd_t                code_q, code_d;
    bcd_t                min_q, min_d;
    bcd_t                tens_q, tens_d;
    bcd_t                sec_q, sec_d;
    logic                strobe_q, strobe_d;

    logic                enc_valid;
    bcd_t                enc_code;
    logic [NUM_KEYS-1:0] held_mask;
    logic                commit;

    keypad_onehot_encoder u_encoder (
        .keys  (s2_q),
        .valid (enc_valid),
        .code  (enc_code)
    );

    assign held_mask = NUM_KEYS'(1) << code_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    code_d  = enc_code;
                    cnt_d   = '0;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (s2_q != held_mask) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    commit  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (s2_q == '0) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // any activity during release restarts the quiet-time count
                if (s2_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        min_d    = min_q;
        tens_d   = tens_q;
        sec_d    = sec_q;
        strobe_d = 1'b0;
        if (clear) begin
            min_d  = '0;
            tens_d = '0;
            sec_d  = '0;
        end else if (commit && entry_en) begin
            min_d    = tens_q;
            tens_d   = sec_q;
            sec_d    = code_q;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            min_q    <= '0;
            tens_q   <= '0;
            sec_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            s1_q     <= keys;
            s2_q     <= s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            min_q    <= min_d;
            tens_q   <= tens_d;
            sec_q    <= sec_d;
            strobe_q <= strobe_d;
        end
    end

    assign Min          = min_q;
    assign TenSec       = tens_q;
    assign Sec          = sec_q;
    assign digit_strobe = strobe_q;
    assign time_nonzero = |{min_q, tens_q, sec_q};

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with DEBOUNCE_CYCLES=4.
module tb_keypad_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] keys = '0;
    logic       entry_en = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] Min, TenSec, Sec;
    logic       digit_strobe, time_nonzero;

    int ncmp = 0;
    int nerr = 0;
    int strobe_cnt = 0;

    keypad_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .keys         (keys),
        .entry_en     (entry_en),
        .clear        (clear),
        .Min          (Min),
        .TenSec       (TenSec),
        .Sec          (Sec),
        .digit_strobe (digit_strobe),
        .time_nonzero (time_nonzero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (digit_strobe) strobe_cnt++;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [9:0] mask, input int hold, input int rel);
        keys = mask;
        wait_neg(hold);
        keys = '0;
        wait_neg(rel);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        keys  = '0;
        wait_neg(2);
        reset = 1'b0;
        ncmp++; if (Min !== 4'd0) begin nerr++; $display("FAIL reset_min: got %0d want 0", Min); end
        ncmp++; if (TenSec !== 4'd0) begin nerr++; $display("FAIL reset_tensec: got %0d want 0", TenSec); end
        ncmp++; if (Sec !== 4'd0) begin nerr++; $display("FAIL reset_sec: got %0d want 0", Sec); end
        ncmp++; if (digit_strobe !== 1'b0) begin nerr++; $display("FAIL reset_strobe: got %b want 0", digit_strobe); end
        ncmp++; if (time_nonzero !== 1'b0) begin nerr++; $display("FAIL reset_nonzero: got %b want 0", time_nonzero); end
    endtask

    task automatic test_entry;
        wait_neg(3);
        strobe_cnt = 0;
        keys = 10'b00_0000_0010;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            ncmp++;
            if (digit_strobe !== (e == 7)) begin
                nerr++; $display("FAIL latency_strobe_edge%0d: got %b want %b", e, digit_strobe, (e == 7));
            end
        end
        ncmp++; if (Sec !== 4'd1) begin nerr++; $display("FAIL latency_sec: got %0d want 1", Sec); end
        @(posedge clk); #1;
        ncmp++; if (digit_strobe !== 1'b0) begin nerr++; $display("FAIL strobe_width: got %b want 0", digit_strobe); end
        @(negedge clk);
        wait_neg(2);
        keys = '0;
        wait_neg(10);
        press_key(10'b00_0000_1000, 10, 10);
        press_key(10'b00_0000_0001, 10, 10);
        ncmp++; if (Min !== 4'd1) begin nerr++; $display("FAIL entry_min: got %0d want 1", Min); end
        ncmp++; if (TenSec !== 4'd3) begin nerr++; $display("FAIL entry_tensec: got %0d want 3", TenSec); end
        ncmp++; if (Sec !== 4'd0) begin nerr++; $display("FAIL entry_sec: got %0d want 0", Sec); end
        ncmp++; if (time_nonzero !== 1'b1) begin nerr++; $display("FAIL entry_nonzero: got %b want 1", time_nonzero); end
        ncmp++; if (strobe_cnt !== 3) begin nerr++; $display("FAIL entry_strobes: got %0d want 3", strobe_cnt); end
    endtask

    task automatic test_invalid;
        strobe_cnt = 0;
        press_key(10'b00_0010_0000, 4, 10);
        press_key(10'b00_1000_0100, 20, 10);
        ncmp++; if (strobe_cnt !== 0) begin nerr++; $display("FAIL invalid_strobes: got %0d want 0", strobe_cnt); end
        ncmp++; if ({Min, TenSec, Sec} !== 12'h130) begin nerr++; $display("FAIL invalid_digits: got %h want 130", {Min, TenSec, Sec}); end
    endtask

    task automatic test_bounce;
        strobe_cnt = 0;
        keys = 10'b10_0000_0000;
        wait_neg(100);
        for (int b = 0; b < 2; b++) begin
            keys = '0;
            wait_neg(2);
            keys = 10'b10_0000_0000;
            wait_neg(3);
        end
        keys = '0;
        wait_neg(12);
        ncmp++; if (strobe_cnt !== 1) begin nerr++; $display("FAIL bounce_strobes: got %0d want 1", strobe_cnt); end
        ncmp++; if ({Min, TenSec, Sec} !== 12'h309) begin nerr++; $display("FAIL bounce_digits: got %h want 309", {Min, TenSec, Sec}); end
    endtask

    task automatic test_clear;
        press_key(10'b00_0000_0010, 10, 10);
        press_key(10'b00_0000_0100, 10, 10);
        press_key(10'b00_0000_1000, 10, 10);
        press_key(10'b00_0001_0000, 10, 10);
        ncmp++; if ({Min, TenSec, Sec} !== 12'h234) begin nerr++; $display("FAIL shift_digits: got %h want 234", {Min, TenSec, Sec}); end
        strobe_cnt = 0;
        keys = 10'b01_0000_0000;
        wait_neg(6);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ncmp++; if ({Min, TenSec, Sec} !== 12'h000) begin nerr++; $display("FAIL clear_digits: got %h want 000", {Min, TenSec, Sec}); end
        ncmp++; if (time_nonzero !== 1'b0) begin nerr++; $display("FAIL clear_nonzero: got %b want 0", time_nonzero); end
        wait_neg(3);
        keys = '0;
        wait_neg(10);
        ncmp++; if (strobe_cnt !== 0) begin nerr++; $display("FAIL clear_strobes: got %0d want 0", strobe_cnt); end
    endtask

    task automatic test_entry_disable;
        press_key(10'b00_0010_0000, 10, 10);
        ncmp++; if ({Min, TenSec, Sec} !== 12'h005) begin nerr++; $display("FAIL pre_disable_digits: got %h want 005", {Min, TenSec, Sec}); end
        strobe_cnt = 0;
        entry_en = 1'b0;
        keys = 10'b00_0100_0000;
        wait_neg(10);
        ncmp++; if ({Min, TenSec, Sec} !== 12'h005) begin nerr++; $display("FAIL disable_digits: got %h want 005", {Min, TenSec, Sec}); end
        entry_en = 1'b1;
        wait_neg(20);
        ncmp++; if (strobe_cnt !== 0) begin nerr++; $display("FAIL disable_strobes: got %0d want 0", strobe_cnt); end
        ncmp++; if ({Min, TenSec, Sec} !== 12'h005) begin nerr++; $display("FAIL reenable_digits: got %h want 005", {Min, TenSec, Sec}); end
        keys = '0;
        wait_neg(10);
        press_key(10'b00_0100_0000, 10, 10);
        ncmp++; if ({Min, TenSec, Sec} !== 12'h056) begin nerr++; $display("FAIL repress_digits: got %h want 056", {Min, TenSec, Sec}); end
        ncmp++; if (strobe_cnt !== 1) begin nerr++; $display("FAIL repress_strobes: got %0d want 1", strobe_cnt); end
    endtask

    task automatic test_reset_midpress;
        keys = 10'b00_0000_1000;
        wait_neg(5);
        reset = 1'b1;
        wait_neg(2);
        strobe_cnt = 0;
        reset = 1'b0;
        ncmp++; if ({Min, TenSec, Sec} !== 12'h000) begin nerr++; $display("FAIL midreset_digits: got %h want 000", {Min, TenSec, Sec}); end
        wait_neg(8);
        ncmp++; if (Sec !== 4'd3) begin nerr++; $display("FAIL midreset_fresh_sec: got %0d want 3", Sec); end
        ncmp++; if (strobe_cnt !== 1) begin nerr++; $display("FAIL midreset_strobes: got %0d want 1", strobe_cnt); end
        keys = '0;
        wait_neg(10);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_invalid();
        test_bounce();
        test_clear();
        test_entry_disable();
        test_reset_midpress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Time-entry front end for the microwave controller. Takes the raw one-hot numeric keypad, synchronizes and debounces it, and accepts exactly one digit per physical press. Each accepted digit shifts into a three-digit BCD time register (minutes : tens-of-seconds : seconds). The Min/TenSec/Sec outputs feed the timer preset and the 7-segment display decoder.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: cycles a single key must be stable, both pressed and released, before it is accepted. Must be ≥1. Use 4 for simulation; the board build overrides it for roughly 10 ms.

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge
- reset  in  1  synchronous, active-high reset
- keys  in  10  raw keypad lines, bit n = digit n, active-high, asynchronous to clk
- entry_en  in  1  digit acceptance enable (low while cooking)
- clear  in  1  synchronous clear of the time register
- Min  out  4  BCD minutes digit
- TenSec  out  4  BCD tens-of-seconds digit
- Sec  out  4  BCD seconds digit
- digit_strobe  out  1  one-cycle pulse in the cycle the new digits first appear
- time_nonzero  out  1  combinational OR of all digit bits

## Operation
- Synchronizer: two flops on keys (s1, s2). The FSM only ever sees s2.
- Validity: s2 is valid when exactly one bit is set. The key code is the index of that bit, 0–9. Zero bits set or more than one bit set is not a valid press.
- FSM states and transitions:
  - IDLE: when s2 is valid, latch the code, set cnt=0, go to PRESS.
  - PRESS: if s2 differs from the latched key, go to IDLE. Otherwise, if cnt==DEBOUNCE_CYCLES-1, commit and go to HELD; else cnt++.
  - HELD: wait until s2==0, then set cnt=0 and go to RELEASE.
  - RELEASE: if s2 is nonzero, set cnt=0 and stay in RELEASE. Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to IDLE; else cnt++.
- Commit with entry_en=1 shifts the register: Min←TenSec, TenSec←Sec, Sec←code. The old Min is discarded.
- Commit with entry_en=0 changes no digits and produces no strobe. The press is still consumed, so the FSM goes to HELD.
- clear=1 sets all three digits to 0 and suppresses the strobe that cycle. The FSM is unaffected. clear beats a simultaneous commit.
- Digits are never range-checked here; values 0–9 only ever enter. Validation of TenSec>5 belongs to the controller.
- cnt width is $clog2(DEBOUNCE_CYCLES)+1. cnt never wraps, because it is reset on every exit condition.

## Timing
- Reset values: Min=TenSec=Sec=0, digit_strobe=0, time_nonzero=0, FSM=IDLE, cnt=0, s1=s2=0.
- Press latency: the key is presented stable before rising edge 1. The digits update and digit_strobe=1 after edge DEBOUNCE_CYCLES+3. With default 4, that is edge 7.
- A press shorter than DEBOUNCE_CYCLES+1 cycles at the input produces no commit.
- A release must also last at least DEBOUNCE_CYCLES cycles before the next press is accepted. Bounce during release restarts the release count and never produces a second digit.
- digit_strobe is high for exactly one cycle per accepted digit. It is registered, aligned with the digit update.
- Reset mid-press returns to IDLE with the digits zeroed. A key still held after reset is then treated as a fresh press.

## Structure
- Package keypad_pkg holds:
  - typedef bcd_t (4-bit)
  - the FSM state enum {IDLE, PRESS, HELD, RELEASE}
  - constant NUM_KEYS=10
- Sub-module keypad_onehot_encoder is combinational. It maps keys[9:0] to {valid, code[3:0]}, with valid=0 for zero-hot or multi-hot inputs.
- The synchronizer, FSM, debounce counter and shift register live in keypad_entry.

## Test plan (DEBOUNCE_CYCLES=4)
- Reset for 2 cycles, then release it -> Min=TenSec=Sec=0, digit_strobe=0, time_nonzero=0.
- Press 1, 3, 0 (each held 10 cycles, released 10, entry_en=1) -> Min=1, TenSec=3, Sec=0, time_nonzero=1. Exactly 3 strobes; the first at edge 7 after key 1 is presented.
- Press 5 for only 4 cycles; separately, press keys 2 and 7 simultaneously for 20 cycles -> no strobe, digits unchanged.
- Hold 9 for 100 cycles with 3-cycle bounce pulses during release -> exactly one strobe, Sec=9.
- Enter 1, 2, 3, 4 -> Min=2, TenSec=3, Sec=4. Then pulse clear in the commit cycle of a fifth press (8) -> all digits 0, no strobe.
- Set entry_en=0 and press 6 -> digits unchanged, no strobe. Set entry_en=1 while still holding 6 -> no commit until release and a re-press.
